seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Parametrised multi-channel debug display engine that replaces the fixed 8-way select-plus-scanner arrangement at the system top. It takes NUM_CH packed hex words, selects one per frame (manual, auto-cycle or freeze), latches it tear-free at frame boundaries, and time-multiplexes DIGITS common-anode-style digit enables with decoded segments. Optional leading-zero blanking is provided. It sits between the CPU/memory debug taps and the board seven-segment pins.

## Interface
- NUM_CH, 8, number of selectable channels (≥2)
- DIGITS, 8, hex digits per channel and digit enables (≥2)
- SCAN_DIV, 1024, clk cycles per digit slot (≥2)
- AUTO_FRAMES, 256, full frames per channel in auto mode (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ch_data  in  NUM_CH*DIGITS*4  channel c occupies bits [c*DIGITS*4 +: DIGITS*4]; nibble d is digit d, LSD = 0
- sel  in  CW=$clog2(NUM_CH)  manual channel select
- mode  in  2  00 manual, 01 auto-cycle, 10 freeze, 11 treated as freeze
- blank_lz  in  1  1 = blank leading zero digits
- seg_out  out  8  active-high segments {dp,g,f,e,d,c,b,a}
- dig_sel  out  DIGITS  one-hot active-high digit enable
- cur_ch  out  CW  channel currently latched for display

## Operation
- Prescaler pcnt counts 0..SCAN_DIV-1; tick when pcnt==SCAN_DIV-1, then pcnt wraps to 0.
- On tick the digit index didx advances; DIGITS-1 wraps to 0. Frame boundary = tick with didx==DIGITS-1.
- At each frame boundary:
  - cur_ch updates by mode: manual → sel, held unchanged if sel≥NUM_CH; auto → increments every AUTO_FRAMES frames, NUM_CH-1 wraps to 0; freeze → unchanged.
  - The frame latch captures ch_data of the new cur_ch, except in freeze.
- Mode changes take effect only at a frame boundary.
- Entering auto from another mode clears the frame counter. The first channel advance therefore comes AUTO_FRAMES frames after entry.
- Leading-zero blanking with blank_lz=1: digit d is blank (seg = 0x00) when d > index of the highest nonzero nibble of the latch. Digit 0 is never blanked, so an all-zero word shows a single "0". blank_lz is sampled combinationally per slot.
- Hex decode, gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- dp (bit 7) is lit on digit 0 only while mode is freeze; otherwise dp is 0.

## Timing
- Reset values: pcnt=0, didx=0, frame counter 0, cur_ch=0, latch=0, seg_out=8'h00, dig_sel=0.
- seg_out and dig_sel are registered and reflect didx/latch one cycle later.
  - First cycle after reset release: dig_sel=…0001, seg_out=8'h3F.
- Each digit is held exactly SCAN_DIV cycles. One frame = DIGITS*SCAN_DIV cycles.
- Latency from a sel change to display is at most one frame plus 1 cycle, and at least 1 cycle.
- dig_sel is never multi-hot. The segment and digit enables change in the same cycle, so there are no ghosting glitches between registered outputs.
- ch_data is assumed stable or unimportant between frame boundaries. Only the boundary-cycle value is used.
- Asserting rst mid-frame immediately forces all reset values. The display restarts at digit 0 with latch 0.

## Structure
- Package seg_pkg holds:
  - mode encodings MODE_MANUAL/MODE_AUTO/MODE_FREEZE
  - the 16-entry hex-to-segment constant table
  - the SEG_BLANK constant
- Sub-module hex7seg_decode: 4-bit nibble in, 7-bit segments out, purely combinational, instantiated once.
- The top contains the prescaler, digit counter, frame/auto counter, latch, blanking priority encoder and output registers.

## Test plan
Bench parameters: NUM_CH=4, DIGITS=8, SCAN_DIV=4, AUTO_FRAMES=2. Frame = 32 cycles.
- Reset, manual, sel=2, ch2=32'h1234_ABCD:
  - After the first frame boundary, digits 0..7 show 5E,39,7C,77,66,4F,5B,06.
  - Each digit lasts 4 cycles.
- blank_lz=1, ch0=32'h0000_00F0, sel=0:
  - Digits 0..1 show 3F,71; digits 2..7 show 00.
  - With ch0=0 → only digit 0 shows 3F.
- Auto mode, all channels distinct: cur_ch sequence 0→1→2→3→0, advancing every 64 cycles, at frame boundaries only.
- Freeze mid-frame, then change ch_data: the display keeps the old value and digit 0 dp=1. Return to manual → new value appears within 33 cycles.
- Change sel at cycle 5 of a frame: the old channel persists until the boundary. sel set to 3→valid, then to an out-of-range value is not possible with CW=2, so re-run with NUM_CH=3 and sel=3 → cur_ch holds.
- Assert rst during digit 5: the next cycle has dig_sel=0 and seg_out=00. After release, dig_sel=…0001 and seg_out=3F.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: mode encodings and seven-segment constants shared by the scan display engine
package seg_pkg;
  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_FREEZE = 2'b10
  } mode_e;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: combinational hex nibble to gfedcba segment pattern
module hex7seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = HEX_SEG[i_nib];
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: selects one of NUM_CH hex words per frame and scans it onto DIGITS seven-segment digits
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 1024,
  parameter int AUTO_FRAMES = 256,
  localparam int CW = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DIGITS*4-1:0] ch_data,
  input  logic [CW-1:0]              sel,
  input  logic [1:0]                 mode,
  input  logic                       blank_lz,
  output logic [7:0]                 seg_out,
  output logic [DIGITS-1:0]          dig_sel,
  output logic [CW-1:0]              cur_ch
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DIGITS);
  localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam int WW = DIGITS * 4;
  logic [PW-1:0]     r_pcnt;
  logic [DW-1:0]     r_didx;
  logic [FW-1:0]     r_fcnt;
  logic [1:0]        r_mode;
  logic [CW-1:0]     r_cur_ch;
  logic [WW-1:0]     r_latch;
  logic [7:0]        r_seg;
  logic [DIGITS-1:0] r_dig;
  logic              w_tick, w_frame, w_auto_wrap, w_blank, w_dp;
  logic [CW-1:0]     w_next_ch;
  logic [WW-1:0]     w_word;
  logic [DW-1:0]     w_hi;
  logic [3:0]        w_nib;
  logic [6:0]        w_hex;
  assign w_tick      = r_pcnt == PW'(SCAN_DIV - 1);
  assign w_frame     = w_tick && r_didx == DW'(DIGITS - 1);
  assign w_auto_wrap = r_fcnt == FW'(AUTO_FRAMES - 1);
  // r_mode is the mode that took effect at the last boundary, so a fresh entry into auto never advances
  always_comb begin
    w_next_ch = r_cur_ch;
    if (mode == MODE_MANUAL)
      w_next_ch = (int'(sel) < NUM_CH) ? sel : r_cur_ch;
    else if (mode == MODE_AUTO && r_mode == MODE_AUTO && w_auto_wrap)
      w_next_ch = (r_cur_ch == CW'(NUM_CH - 1)) ? '0 : r_cur_ch + 1'b1;
  end
  assign w_word = ch_data[int'(w_next_ch)*WW +: WW];
  always_comb begin
    w_hi = '0;
    for (int d = 1; d < DIGITS; d++)
      if (r_latch[d*4 +: 4] != 4'h0) w_hi = DW'(d);
  end
  assign w_nib   = r_latch[{r_didx, 2'b00} +: 4];
  assign w_blank = blank_lz && r_didx > w_hi;
  assign w_dp    = r_mode[1] && r_didx == '0;
  hex7seg_decode u_dec (
    .i_nib(w_nib),
    .o_seg(w_hex)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt   <= '0;
      r_didx   <= '0;
      r_fcnt   <= '0;
      r_mode   <= MODE_MANUAL;
      r_cur_ch <= '0;
      r_latch  <= '0;
      r_seg    <= SEG_BLANK;
      r_dig    <= '0;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
      if (w_tick) r_didx <= (r_didx == DW'(DIGITS - 1)) ? '0 : r_didx + 1'b1;
      if (w_frame) begin
        r_mode   <= mode;
        r_cur_ch <= w_next_ch;
        r_fcnt   <= (r_mode != MODE_AUTO || w_auto_wrap) ? '0 : r_fcnt + 1'b1;
        if (!mode[1]) r_latch <= w_word;
      end
      r_dig <= DIGITS'(1) << r_didx;
      r_seg <= w_blank ? SEG_BLANK : {w_dp, w_hex};
    end
  end
  assign seg_out = r_seg;
  assign dig_sel = r_dig;
  assign cur_ch  = r_cur_ch;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed cycle-exact checks of scanning, blanking, auto/freeze modes and reset
module tb_seg_scan_mux;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] ch_data;
  logic [95:0]  ch3_data;
  logic [1:0]   sel, sel3, mode, cur_ch, cur3;
  logic         blank_lz;
  logic [7:0]   seg_out, seg3, dig_sel, dig3;
  int n_tests = 0, n_fail = 0, cyc = 0;
  always #5 clk = ~clk;
  seg_scan_mux #(.NUM_CH(4), .DIGITS(8), .SCAN_DIV(4), .AUTO_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .sel(sel), .mode(mode),
    .blank_lz(blank_lz), .seg_out(seg_out), .dig_sel(dig_sel), .cur_ch(cur_ch)
  );
  seg_scan_mux #(.NUM_CH(3), .DIGITS(8), .SCAN_DIV(4), .AUTO_FRAMES(2)) dut3 (
    .clk(clk), .rst(rst), .ch_data(ch3_data), .sel(sel3), .mode(mode),
    .blank_lz(1'b0), .seg_out(seg3), .dig_sel(dig3), .cur_ch(cur3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic go(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    #1;
    chk("rst_dig", dig_sel, 0);
    chk("rst_seg", seg_out, 0);
    chk("rst_ch", cur_ch, 0);
    @(negedge clk);
    chk("rst_dig_next", dig_sel, 0);
    chk("rst_seg_next", seg_out, 0);
    rst = 1'b0;
    cyc = 0;
  endtask
  task automatic show(input string tag, input int t, input logic [7:0] s, input logic [7:0] d);
    go(t);
    chk({tag, "_seg"}, seg_out, s);
    chk({tag, "_dig"}, dig_sel, d);
  endtask
  logic [7:0] t1 [8] = '{8'h5E, 8'h39, 8'h7C, 8'h77, 8'h66, 8'h4F, 8'h5B, 8'h06};
  logic [7:0] t2 [8] = '{8'h3F, 8'h71, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  initial begin
    mode = 2'b00; sel = 2'd2; sel3 = 2'd1; blank_lz = 1'b0;
    ch_data  = {32'h4444_4444, 32'h1234_ABCD, 32'h2222_2222, 32'h1111_1111};
    ch3_data = {32'hCCCC_CCCC, 32'h0000_0007, 32'hAAAA_AAAA};
    @(negedge clk);
    // manual channel 2, full digit sweep with 4-cycle dwell
    do_reset();
    show("first", 1, 8'h3F, 8'h01);
    chk("first_ch", cur_ch, 0);
    show("pre_bound", 32, 8'h3F, 8'h80);
    chk("bound_ch", cur_ch, 2);
    for (int d = 0; d < 8; d++) begin
      show("m_start", 33 + 4*d, t1[d], 8'(1 << d));
      show("m_end", 36 + 4*d, t1[d], 8'(1 << d));
    end
    // leading-zero blanking
    blank_lz = 1'b1; sel = 2'd0; ch_data[31:0] = 32'h0000_00F0;
    go(cyc + 1);
    do_reset();
    for (int d = 0; d < 8; d++) show("lz", 34 + 4*d, t2[d], 8'(1 << d));
    ch_data[31:0] = 32'h0;
    show("lz0_d0", 66, 8'h3F, 8'h01);
    for (int d = 1; d < 8; d++) show("lz0", 66 + 4*d, 8'h00, 8'(1 << d));
    blank_lz = 1'b0;
    // auto cycling, entered mid-frame
    ch_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    go(cyc + 1);
    do_reset();
    go(40); mode = 2'b01;
    go(64);  chk("auto_entry", cur_ch, 0);
    go(127); chk("auto_pre1", cur_ch, 0);
    go(128); chk("auto_1", cur_ch, 1);
    show("auto_1", 129, 8'h5B, 8'h01);
    go(160); chk("auto_hold", cur_ch, 1);
    go(191); chk("auto_pre2", cur_ch, 1);
    go(192); chk("auto_2", cur_ch, 2);
    go(256); chk("auto_3", cur_ch, 3);
    show("auto_3", 257, 8'h66, 8'h01);
    go(320); chk("auto_wrap", cur_ch, 0);
    show("auto_0", 321, 8'h06, 8'h01);
    mode = 2'b00;
    // freeze holds the latched word and lights dp on digit 0
    sel = 2'd1;
    go(cyc + 1);
    do_reset();
    show("pre_frz", 33, 8'h5B, 8'h01);
    go(40); mode = 2'b10;
    go(50); ch_data[63:32] = 32'h5555_5555;
    show("frz_d0", 65, 8'hDB, 8'h01);
    chk("frz_ch", cur_ch, 1);
    show("frz_d1", 69, 8'h5B, 8'h02);
    go(70); mode = 2'b00;
    show("frz_end", 96, 8'h5B, 8'h80);
    show("unfrz", 97, 8'h6D, 8'h01);
    // sel change mid-frame; out-of-range sel on the 3-channel instance
    go(cyc + 1);
    do_reset();
    go(37); chk("sel_old", cur_ch, 1);
    sel = 2'd3; sel3 = 2'd3;
    show("sel_keep", 60, 8'h6D, 8'h40);
    go(63); chk("sel_pre", cur_ch, 1);
    go(64); chk("sel_new", cur_ch, 3); chk("oor_ch", cur3, 1);
    show("sel_new", 65, 8'h66, 8'h01);
    chk("oor_seg", seg3, 8'h07); chk("oor_dig", dig3, 8'h01);
    go(97); chk("oor_ch2", cur3, 1); chk("oor_seg2", seg3, 8'h07);
    // reset asserted during digit 5
    sel = 2'd0; ch_data[31:0] = 32'h7654_3210;
    go(cyc + 1);
    do_reset();
    show("r_d1", 37, 8'h06, 8'h02);
    show("r_d5", 53, 8'h6D, 8'h20);
    go(54);
    do_reset();
    show("r_after", 1, 8'h3F, 8'h01);
    show("r_after_d1", 37, 8'h06, 8'h02);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
